// File: rtl/isa_pkg.sv
// Shared ISA constants for the ARM-subset loader: op classes, DP commands,
// condition codes, compare-command set and loader sequencer states.
package isa_pkg;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [1:0] {
    ST_READY,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic is_cmp_cmd(logic [3:0] c);
    return (c == CMD_CMP) || (c == CMD_TST) ||
           (c == CMD_CMN) || (c == CMD_TEQ);
  endfunction

  function automatic logic is_legal_cmd(logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) ||
           (c == CMD_AND) || (c == CMD_ORR) ||
           (c == CMD_ADC) || (c == CMD_EOR) ||
           (c == CMD_MOV) || is_cmp_cmd(c);
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: decoded fields -> 32-bit instruction word + legality.
// In: class, cond, cmd, imm, s, load, rn, rd, src2, imm24. Out: word, legal.
module instr_packer
  import isa_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [3:0]  cond,
  input  logic [3:0]  cmd,
  input  logic        imm,
  input  logic        s,
  input  logic        load,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] imm24,
  output logic [31:0] word,
  output logic        legal
);

  logic       cmp;
  logic       s_eff;
  logic [3:0] rd_eff;

  // Compare-type ops always set flags and have no destination.
  assign cmp    = is_cmp_cmd(cmd);
  assign s_eff  = cmp ? 1'b1 : s;
  assign rd_eff = cmp ? 4'd0 : rd;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (cls)
      CLS_DP: begin
        word  = {cond, 2'b00, imm, cmd, s_eff,
                 rn, rd_eff, src2};
        legal = is_legal_cmd(cmd);
      end
      CLS_MEM: begin
        // P=1 U=1 B=0 W=0; I bit is inverted
        word  = {cond, 2'b01, ~imm, 1'b1, 1'b1,
                 1'b0, 1'b0, load, rn, rd, src2};
        legal = 1'b1;
      end
      CLS_B: begin
        word  = {cond, 2'b10, 2'b10, imm24};
        legal = 1'b1;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/prog_image_writer.sv
// Loader sequencer: accepts field bundles, packs and writes them to imem.
// Ports: handshake in, imem write port out, count/done/error status out.
module prog_image_writer
  import isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_cmd,
  input  logic              in_imm,
  input  logic              in_s,
  input  logic              in_load,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE =
    BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0] CAP =
    {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [31:0] pk_word;
  logic        pk_legal;

  instr_packer u_packer (
    .cls   (in_class),
    .cond  (in_cond),
    .cmd   (in_cmd),
    .imm   (in_imm),
    .s     (in_s),
    .load  (in_load),
    .rn    (in_rn),
    .rd    (in_rd),
    .src2  (in_src2),
    .imm24 (in_imm24),
    .word  (pk_word),
    .legal (pk_legal)
  );

  assign in_ready   = (state_q == ST_READY);
  assign imem_we    = we_q;
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    last_d  = last_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      ST_READY: begin
        if (in_valid) begin
          // A full image rejects further words without writing.
          if (!pk_legal || count_q == CAP) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
            wdata_d = pk_word;
            last_d  = in_last;
          end
        end
      end
      ST_WRITE: begin
        ptr_d   = ptr_q + ADDR_W'(1);
        count_d = count_q + (ADDR_W + 1)'(1);
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_READY;
          ptr_d   = BASE;
          count_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_READY;
      ptr_q   <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      last_q  <= last_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: doc/prog_image_writer.md
# prog_image_writer

Loader-side encoder for the single-cycle ARM subset. It accepts decoded instruction fields over a valid/ready handshake and packs each into a 32-bit instruction word in the exact layout the control decoder consumes. Each packed word is written sequentially into instruction memory through a one-cycle write port. It drives imem fill at bring-up, before the core is released, and owns the write pointer, word count, end-of-program and error status.

## Interface
- ADDR_W, 6: instruction memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0: first word address written after reset or restart.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  re-arm pulse. Honoured only in DONE/ERROR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  high only in READY.
- in_class  in  2  op class: 00 DP, 01 MEM, 10 B; 11 illegal.
- in_cond  in  4  condition field.
- in_cmd  in  4  DP command.
- in_imm  in  1  DP: I bit; MEM: 1 = immediate offset.
- in_s  in  1  DP S bit.
- in_load  in  1  MEM: 1 LDR, 0 STR.
- in_rn, in_rd  in  4 each  register numbers.
- in_src2  in  12  Src2 / offset field.
- in_imm24  in  24  branch offset.
- in_last  in  1  final instruction of the image.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  packed word.
- count  out  ADDR_W+1  words written since reset or start.
- done  out  1  image complete, sticky.
- error  out  1  rejected input, sticky.

## Operation
- Legal DP commands: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP, 1000 TST, 1011 CMN, 0101 ADC, 0001 EOR, 1001 TEQ, 1101 shift/MOV. Every other command code is illegal.
- DP word: {cond, 00, I, cmd, S, Rn, Rd, src2}.
- For CMP/TST/CMN/TEQ, S is forced to 1 and Rd to 0, regardless of in_s/in_rd.
- MEM word: {cond, 01, ~in_imm, P=1, U=1, B=0, W=0, L=in_load, Rn, Rd, src2}.
- B word: {cond, 10, 10, imm24}.
- States and transitions:
  - READY: wait for in_valid.
  - READY → WRITE on a legal handshake; the packed word is latched.
  - READY → ERROR on a handshake with an illegal class or cmd, or when count == 2^ADDR_W. No write occurs.
  - WRITE → DONE if the latched word had in_last, else WRITE → READY. In both cases the pointer and count increment.
  - DONE/ERROR: if start=1, go to READY with pointer = BASE_ADDR, count = 0, done and error cleared.
- Pointer increment wraps modulo 2^ADDR_W. Overflow is detected only via count.
- start in READY or WRITE is ignored.
- reset wins over every other event, including a WRITE in progress.

## Timing
- Handshake at edge N → imem_we=1 during cycle N+1, with imem_addr/imem_wdata stable that cycle → in_ready back high in cycle N+2.
- Peak throughput: one word per 2 cycles.
- count, done and error update at the edge ending the WRITE or error-detect cycle.
- in_ready is a combinational decode of state and must not depend on in_valid.
- Reset values: state READY, in_ready 1, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, count 0, done 0, error 0.
- Reset asserted during WRITE: no strobe in the following cycle, and count is not incremented.

## Structure
- Shared package isa_pkg: class codes, DP cmd codes, cond AL = 1110, compare-command set, and the state enum (READY, WRITE, DONE, ERROR).
- Sub-module instr_packer: purely combinational field-to-word packing plus the legality flag. It is reused by the bench as a reference model.
- The sequencer, pointer and count live in prog_image_writer.

## Test plan
- ADD R2,R3,#5 (class 00, AL, cmd 0100, I=1, S=0) → one strobe at BASE_ADDR, wdata 0xE2832005, count 1.
- CMP R1,#0 with in_s=0, in_rd=7 → wdata 0xE3510000 (S forced 1, Rd forced 0).
- LDR R4,[R5,#8], then STR with the same fields, then B imm24=2 with in_last=1 → words 0xE5954008, 0xE5854008, 0xEA000002 at addresses 0,1,2. done=1 after the third strobe, in_ready=0 afterwards.
- class 11 or cmd 0111 → no strobe, error=1, in_ready=0. start → READY, count 0, error 0.
- ADDR_W=2: present 4 words, then a 5th → 4 strobes at addresses 0-3, 5th raises error with no write.
- reset asserted in the WRITE cycle → imem_we low next cycle, all outputs at reset values.
